attack_arbiter: RTL

ATTACK_ARBITER -- requirements
Module: attack_arbiter

---
 rtl/attack_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/attack_arbiter.sv
// Two-player shared attack-slot arbiter: grants one timed attack window, resolves hit/block, then cools down.
// Optional feature macro ATTACK_ARBITER_CLASH_EN: simultaneous requests clash (no grant) instead of using priority.
module attack_arbiter #(
   parameter int ATTACK_FRAMES   = 12,
   parameter int COOLDOWN_FRAMES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic game_over,
   input  logic p1_attack_req,
   input  logic p2_attack_req,
   input  logic p1_shielding,
   input  logic p2_shielding,
   input  logic player_collision,
   input  logic p1_facing_p2,
   input  logic p2_facing_p1,
   output logic p1_attack_grant,
   output logic p2_attack_grant,
   output logic p1_hit,
   output logic p2_hit,
   output logic p1_block,
   output logic p2_block,
   output logic clash
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ATTACK   = 2'd1;
   localparam logic [1:0] S_RESOLVE  = 2'd2;
   localparam logic [1:0] S_COOLDOWN = 2'd3;
   localparam logic       P1         = 1'b0;
   localparam logic       P2         = 1'b1;
   localparam logic [5:0] ATT_LOAD   = 6'(ATTACK_FRAMES);
   localparam logic [5:0] COOL_LOAD  = 6'(COOLDOWN_FRAMES);

   logic [1:0] state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;
   logic       prio_q, prio_d;
   logic       g1_d, g2_d, h1_d, h2_d, b1_d, b2_d, clash_d;
   logic       both_req_s, strike_s, shielded_s;

   assign both_req_s = p1_attack_req & p2_attack_req;
   assign strike_s   = player_collision & ((owner_q == P1) ? p1_facing_p2 : p2_facing_p1);
   assign shielded_s = (owner_q == P1) ? p2_shielding : p1_shielding;

   // Next-state, counter, owner/priority and pulse decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      h1_d    = 1'b0;
      h2_d    = 1'b0;
      b1_d    = 1'b0;
      b2_d    = 1'b0;
      clash_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (both_req_s) begin
`ifdef ATTACK_ARBITER_CLASH_EN
               clash_d = 1'b1;
               state_d = S_COOLDOWN;
               cnt_d   = COOL_LOAD;
`else
               owner_d = prio_q;
               prio_d  = ~prio_q;
               state_d = S_ATTACK;
               cnt_d   = ATT_LOAD;
`endif
            end else if (p1_attack_req) begin
               owner_d = P1;
               state_d = S_ATTACK;
               cnt_d   = ATT_LOAD;
            end else if (p2_attack_req) begin
               owner_d = P2;
               state_d = S_ATTACK;
               cnt_d   = ATT_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ATTACK: begin
            if (frame_tick) begin
               cnt_d = cnt_q - 6'd1;
               if (cnt_q <= 6'd1) begin
                  state_d = S_RESOLVE;
                  cnt_d   = 6'd0;
               end else begin
                  state_d = S_ATTACK;
               end
            end else begin
               state_d = S_ATTACK;
            end
         end
         S_RESOLVE: begin
            // Pulses target the defender, i.e. the player that does not own the slot
            if (strike_s) begin
               if (owner_q == P1) begin
                  h2_d = ~shielded_s;
                  b2_d = shielded_s;
               end else begin
                  h1_d = ~shielded_s;
                  b1_d = shielded_s;
               end
            end else begin
               h1_d = 1'b0;
            end
            state_d = S_COOLDOWN;
            cnt_d   = COOL_LOAD;
         end
         S_COOLDOWN: begin
            if (frame_tick) begin
               cnt_d = cnt_q - 6'd1;
               if (cnt_q <= 6'd1) begin
                  state_d = S_IDLE;
                  cnt_d   = 6'd0;
               end else begin
                  state_d = S_COOLDOWN;
               end
            end else begin
               state_d = S_COOLDOWN;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
      // A finished game freezes everything except the held priority/owner
      if (game_over) begin
         state_d = S_IDLE;
         cnt_d   = 6'd0;
         owner_d = owner_q;
         prio_d  = prio_q;
         h1_d    = 1'b0;
         h2_d    = 1'b0;
         b1_d    = 1'b0;
         b2_d    = 1'b0;
         clash_d = 1'b0;
      end else begin
         cnt_d = cnt_d;
      end
      g1_d = (state_d == S_ATTACK) & (owner_d == P1);
      g2_d = (state_d == S_ATTACK) & (owner_d == P2);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         cnt_q           <= 6'd0;
         owner_q         <= P1;
         prio_q          <= P1;
         p1_attack_grant <= 1'b0;
         p2_attack_grant <= 1'b0;
         p1_hit          <= 1'b0;
         p2_hit          <= 1'b0;
         p1_block        <= 1'b0;
         p2_block        <= 1'b0;
         clash           <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         owner_q         <= owner_d;
         prio_q          <= prio_d;
         p1_attack_grant <= g1_d;
         p2_attack_grant <= g2_d;
         p1_hit          <= h1_d;
         p2_hit          <= h2_d;
         p1_block        <= b1_d;
         p2_block        <= b2_d;
         clash           <= clash_d;
      end
   end

endmodule
